baccarat_sequencer: RTL and testbench
=====================================

Name: baccarat_sequencer

Overview:
- Control FSM for the baccarat datapath. It steps the six card registers (player cards 1-3, dealer cards 1-3) through one round.
- It applies the third-card drawing rules using the datapath's live scores and the player's third card.
- It drives the win indications and a saturating round counter.
- It sits between the top level (slow clock from the push-button, resetb from KEY[3]) and the datapath. It replaces ad-hoc load sequencing.

Parameters:
- AUTO_RESTART, 0, when 1 a step in DONE starts a new round via CLEAR; when 0, DONE holds until reset.
- RW, 8, width of the rounds_played counter.

Ports:
- slow_clock  in  1  sole clock; all state changes on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- step  in  1  advance enable; FSM holds state when low.
- pscore  in  4  player hand score (0-9) from the datapath, combinational from the card registers.
- dscore  in  4  dealer hand score (0-9) from the datapath.
- pcard3  in  4  player third-card rank (1-13) from the datapath register.
- load_pcard1, load_pcard2, load_pcard3  out  1 each  datapath load strobes.
- load_dcard1, load_dcard2, load_dcard3  out  1 each  datapath load strobes.
- clear_hands  out  1  synchronous clear request to all six card registers.
- player_win  out  1  player win indication.
- dealer_win  out  1  dealer win indication.
- done  out  1  round complete.
- rounds_played  out  RW  completed-round count, saturating.

Behaviour:
- Reset: resetb=0 forces state IDLE asynchronously and clears rounds_played to 0. All outputs are 0 while in reset, and immediately after if already mid-round.
- Outputs are Moore outputs of the state, ANDed with step. The datapath captures a card on the same edge that leaves the strobing state.
- step=0 at a rising edge: state holds and no strobe is active.
- All transitions below occur at a rising edge with step=1.
- IDLE -> P1 -> D1 -> P2 -> D2 -> EVAL.
- P1, D1, P2, D2 assert load_pcard1, load_dcard1, load_pcard2, load_dcard2 respectively.
- EVAL (no strobes; scores now reflect four cards):
  - if pscore>=8 or dscore>=8 (natural) -> DONE.
  - else if pscore<=5 -> P3.
  - else (pscore 6 or 7): if dscore<=5 -> D3, else -> DONE.
- P3: asserts load_pcard3, then -> EVAL3.
- EVAL3 (pcard3 now valid): card value v = pcard3 when pcard3<=9, else 0. Dealer draws (-> D3) when any of the following holds, otherwise -> DONE:
  - dscore<=2
  - dscore==3 and v!=8
  - dscore==4 and v in 2..7
  - dscore==5 and v in 4..7
  - dscore==6 and v in 6..7
  - (dscore==7 never draws)
- D3: asserts load_dcard3, then -> DONE.
- DONE:
  - done=1. These outputs are not gated by step.
  - player_win = (pscore>=dscore); dealer_win = (dscore>=pscore). A tie lights both.
  - Win outputs are combinational from live scores and valid only in DONE; otherwise 0.
- rounds_played increments by 1 on the edge entering DONE and saturates at 2^RW-1.
- DONE with AUTO_RESTART=1 and step=1 -> CLEAR. CLEAR asserts clear_hands for exactly one cycle, then -> P1.
- DONE with AUTO_RESTART=0: stays in DONE regardless of step.
- Score inputs >9 or pcard3 of 0 or >13 are illegal. They are treated by plain comparison; no checking is required.
- Unreachable state encodings -> IDLE on the next edge.

Decomposition:
- baccarat_pkg: state enum (IDLE, P1, D1, P2, D2, EVAL, P3, EVAL3, D3, DONE, CLEAR), card-value function (rank -> 0-9), and constants NATURAL_MIN=8 and PLAYER_STAND_MIN=6.
- One sub-module, banker_draw_rule: combinational dscore[3:0] and pcard3[3:0] -> draw. It is instantiated in EVAL3 logic and unit-tested exhaustively (10x13).

Test Plan:
- Reset, step=1, scores held 0 until EVAL, then pscore=6, dscore=0.
  - Strobes in order p1, d1, p2, d2 on edges 2-5; D3 entered on edge 6.
  - Set dscore=9 after edge 7 -> done=1, dealer_win=1, player_win=0, rounds_played=1.
- Natural: at EVAL pscore=8, dscore=3 -> next state DONE, no load_pcard3/load_dcard3 pulse, player_win=1.
- Player draws: pscore=4, dscore=5 at EVAL; pcard3=12 (v=0) -> EVAL3 goes to DONE (no D3).
  - Repeat with pcard3=4 -> D3 entered, load_dcard3 pulses once.
- step=0 for 3 edges while in D1: state holds, all strobes 0. Resume -> next strobe is load_pcard2.
- AUTO_RESTART=1: in DONE assert step -> clear_hands high one cycle, then load_pcard1. rounds_played=RW'(2) after the second round. Force 255 rounds -> stays 255.
- resetb asserted asynchronously mid-P3 (between edges) -> outputs 0 immediately, rounds_played=0, state IDLE; first step edge returns to P1.

Source files
------------

// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared definitions for the baccarat round sequencer:
//   state_t           - FSM states for one round of play
//   NATURAL_MIN       - two-card total at or above which a hand is a natural
//   PLAYER_STAND_MIN  - total at or above which a hand stands on two cards
//   card_value()      - card rank (1..13) to point value (0..9)
// -----------------------------------------------------------------------------
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        P1    = 4'd1,
        D1    = 4'd2,
        P2    = 4'd3,
        D2    = 4'd4,
        EVAL  = 4'd5,
        P3    = 4'd6,
        EVAL3 = 4'd7,
        D3    = 4'd8,
        DONE  = 4'd9,
        CLEAR = 4'd10
    } state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

    // Ten and the face cards count zero; everything else counts its rank.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank <= 4'd9) ? rank : 4'd0;
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// -----------------------------------------------------------------------------
// banker_draw_rule
// Dealer third-card decision once the player has drawn a third card.
//   dscore [3:0] in  - dealer two-card total (0..9)
//   pcard3 [3:0] in  - player third-card rank (1..13)
//   draw         out - 1 when the dealer must take a third card
// -----------------------------------------------------------------------------
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] value;

    assign value = card_value(pcard3);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (value != 4'd8);
            4'd4:             draw = (value >= 4'd2) && (value <= 4'd7);
            4'd5:             draw = (value >= 4'd4) && (value <= 4'd7);
            4'd6:             draw = (value >= 4'd6) && (value <= 4'd7);
            // 7 stands; 8 and 9 cannot reach this point in legal play.
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_sequencer.sv
// -----------------------------------------------------------------------------
// baccarat_sequencer
// Control FSM that deals one baccarat round into the card datapath, applies
// the third-card rules and reports the winner.
//   slow_clock           in  - sole clock (push-button derived)
//   resetb               in  - asynchronous active-low reset
//   step                 in  - advance enable; state holds and strobes are
//                              suppressed while low
//   pscore, dscore [3:0] in  - live hand totals from the datapath
//   pcard3 [3:0]         in  - player third-card rank from the datapath
//   load_pcard1..3       out - player card load strobes
//   load_dcard1..3       out - dealer card load strobes
//   clear_hands          out - one-cycle clear of all card registers
//   player_win           out - player total >= dealer total (DONE only)
//   dealer_win           out - dealer total >= player total (DONE only)
//   done                 out - round complete
//   rounds_played [RW-1:0] out - saturating count of completed rounds
// -----------------------------------------------------------------------------
module baccarat_sequencer
    import baccarat_pkg::*;
#(
    parameter bit AUTO_RESTART = 1'b0,
    parameter int RW           = 8
)
(
    input  logic          slow_clock,
    input  logic          resetb,
    input  logic          step,
    input  logic [3:0]    pscore,
    input  logic [3:0]    dscore,
    input  logic [3:0]    pcard3,
    output logic          load_pcard1,
    output logic          load_pcard2,
    output logic          load_pcard3,
    output logic          load_dcard1,
    output logic          load_dcard2,
    output logic          load_dcard3,
    output logic          clear_hands,
    output logic          player_win,
    output logic          dealer_win,
    output logic          done,
    output logic [RW-1:0] rounds_played
);

    localparam logic [RW-1:0] ROUNDS_MAX = '1;

    state_t state;
    logic   banker_draw;

    function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] count);
        return (count == ROUNDS_MAX) ? count : count + RW'(1);
    endfunction

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    // Every path into DONE bumps the round counter on the same edge.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state         <= IDLE;
            rounds_played <= '0;
        end else begin
            case (state)
                IDLE:  if (step) state <= P1;
                P1:    if (step) state <= D1;
                D1:    if (step) state <= P2;
                P2:    if (step) state <= D2;
                D2:    if (step) state <= EVAL;
                EVAL: begin
                    if (step) begin
                        if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) begin
                            state         <= DONE;
                            rounds_played <= sat_inc(rounds_played);
                        end else if (pscore < PLAYER_STAND_MIN) begin
                            state <= P3;
                        end else if (dscore < PLAYER_STAND_MIN) begin
                            // Player stood on 6/7: dealer uses the same
                            // stand threshold as the player.
                            state <= D3;
                        end else begin
                            state         <= DONE;
                            rounds_played <= sat_inc(rounds_played);
                        end
                    end
                end
                P3:    if (step) state <= EVAL3;
                EVAL3: begin
                    if (step) begin
                        if (banker_draw) begin
                            state <= D3;
                        end else begin
                            state         <= DONE;
                            rounds_played <= sat_inc(rounds_played);
                        end
                    end
                end
                D3: begin
                    if (step) begin
                        state         <= DONE;
                        rounds_played <= sat_inc(rounds_played);
                    end
                end
                DONE:  if (step && AUTO_RESTART) state <= CLEAR;
                CLEAR: if (step) state <= P1;
                // Unused encodings recover regardless of step.
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are state decodes gated by step so a held FSM never reloads.
    assign load_pcard1 = step && (state == P1);
    assign load_dcard1 = step && (state == D1);
    assign load_pcard2 = step && (state == P2);
    assign load_dcard2 = step && (state == D2);
    assign load_pcard3 = step && (state == P3);
    assign load_dcard3 = step && (state == D3);
    assign clear_hands = step && (state == CLEAR);

    assign done       = (state == DONE);
    assign player_win = done && (pscore >= dscore);
    assign dealer_win = done && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_sequencer.sv
module tb_baccarat_sequencer;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_CLR  = 7'b1000000;
    localparam logic [6:0] S_P1   = 7'b0100000;
    localparam logic [6:0] S_D1   = 7'b0010000;
    localparam logic [6:0] S_P2   = 7'b0001000;
    localparam logic [6:0] S_D2   = 7'b0000100;
    localparam logic [6:0] S_P3   = 7'b0000010;
    localparam logic [6:0] S_D3   = 7'b0000001;

    logic       clk = 1'b0;
    logic       resetb_a, resetb_b, step;
    logic [3:0] pscore, dscore, pcard3;

    logic       lp1_a, lp2_a, lp3_a, ld1_a, ld2_a, ld3_a, clr_a, pw_a, dw_a, done_a;
    logic       lp1_b, lp2_b, lp3_b, ld1_b, ld2_b, ld3_b, clr_b, pw_b, dw_b, done_b;
    logic [7:0] rounds_a, rounds_b;
    logic [6:0] sa, sb;

    logic [3:0] rule_d, rule_c;
    logic       rule_draw;

    // Hand-derived dealer draw table: bit r set when rank r makes the dealer draw.
    logic [13:0] draw_mask [10];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign sa = {clr_a, lp1_a, ld1_a, lp2_a, ld2_a, lp3_a, ld3_a};
    assign sb = {clr_b, lp1_b, ld1_b, lp2_b, ld2_b, lp3_b, ld3_b};

    baccarat_sequencer #(.AUTO_RESTART(1'b0), .RW(8)) dut_a (
        .slow_clock(clk), .resetb(resetb_a), .step(step),
        .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
        .load_pcard1(lp1_a), .load_pcard2(lp2_a), .load_pcard3(lp3_a),
        .load_dcard1(ld1_a), .load_dcard2(ld2_a), .load_dcard3(ld3_a),
        .clear_hands(clr_a), .player_win(pw_a), .dealer_win(dw_a),
        .done(done_a), .rounds_played(rounds_a)
    );

    baccarat_sequencer #(.AUTO_RESTART(1'b1), .RW(8)) dut_b (
        .slow_clock(clk), .resetb(resetb_b), .step(step),
        .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
        .load_pcard1(lp1_b), .load_pcard2(lp2_b), .load_pcard3(lp3_b),
        .load_dcard1(ld1_b), .load_dcard2(ld2_b), .load_dcard3(ld3_b),
        .clear_hands(clr_b), .player_win(pw_b), .dealer_win(dw_b),
        .done(done_b), .rounds_played(rounds_b)
    );

    banker_draw_rule u_rule (
        .dscore(rule_d), .pcard3(rule_c), .draw(rule_draw)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic edge_wait();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_a();
        resetb_a = 1'b0;
        step     = 1'b1;
        pscore   = 4'd0;
        dscore   = 4'd0;
        pcard3   = 4'd1;
        #1;
        check("a_rst_strobes", 32'(sa), 32'(S_NONE));
        check("a_rst_done", 32'(done_a), 32'd0);
        check("a_rst_rounds", 32'(rounds_a), 32'd0);
        resetb_a = 1'b1;
    endtask

    task automatic deal_to_eval_a();
        reset_a();
        edge_wait(); #1; check("a_p1", 32'(sa), 32'(S_P1));
        edge_wait(); #1; check("a_d1", 32'(sa), 32'(S_D1));
        edge_wait(); #1; check("a_p2", 32'(sa), 32'(S_P2));
        edge_wait(); #1; check("a_d2", 32'(sa), 32'(S_D2));
        edge_wait();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        draw_mask[0] = 14'h3FFE; draw_mask[1] = 14'h3FFE; draw_mask[2] = 14'h3FFE;
        draw_mask[3] = 14'h3EFE; draw_mask[4] = 14'h00FC; draw_mask[5] = 14'h00F0;
        draw_mask[6] = 14'h00C0; draw_mask[7] = 14'h0000; draw_mask[8] = 14'h0000;
        draw_mask[9] = 14'h0000;
        resetb_a = 1'b0; resetb_b = 1'b0; step = 1'b0;
        pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd1;

        // Exhaustive dealer rule table.
        for (int d = 0; d < 10; d++) begin
            for (int r = 1; r <= 13; r++) begin
                rule_d = 4'(d);
                rule_c = 4'(r);
                #1;
                check($sformatf("rule_d%0d_r%0d", d, r), 32'(rule_draw), 32'(draw_mask[d][r]));
            end
        end

        // Round: player 6 stands, dealer 0 draws, dealer then shows 9.
        deal_to_eval_a();
        pscore = 4'd6; dscore = 4'd0; #1;
        check("eval_strobes", 32'(sa), 32'(S_NONE));
        check("eval_wins", 32'({pw_a, dw_a, done_a}), 32'd0);
        edge_wait(); #1; check("d3_after_eval", 32'(sa), 32'(S_D3));
        edge_wait(); dscore = 4'd9; #1;
        check("r1_done", 32'(done_a), 32'd1);
        check("r1_dealer_win", 32'(dw_a), 32'd1);
        check("r1_player_win", 32'(pw_a), 32'd0);
        check("r1_rounds", 32'(rounds_a), 32'd1);
        edge_wait(); #1;
        check("r1_hold_done", 32'(done_a), 32'd1);
        check("r1_hold_rounds", 32'(rounds_a), 32'd1);
        check("r1_hold_strobes", 32'(sa), 32'(S_NONE));

        // Natural 8 vs 3.
        deal_to_eval_a();
        pscore = 4'd8; dscore = 4'd3; #1;
        check("nat_eval_strobes", 32'(sa), 32'(S_NONE));
        edge_wait(); #1;
        check("nat_strobes", 32'(sa), 32'(S_NONE));
        check("nat_done", 32'(done_a), 32'd1);
        check("nat_pw", 32'(pw_a), 32'd1);
        check("nat_dw", 32'(dw_a), 32'd0);
        check("nat_rounds", 32'(rounds_a), 32'd1);

        // Player draws a face card: dealer 5 stands on value 0.
        deal_to_eval_a();
        pscore = 4'd4; dscore = 4'd5;
        edge_wait(); #1; check("pd_p3", 32'(sa), 32'(S_P3));
        pcard3 = 4'd12;
        edge_wait(); #1;
        check("pd_eval3", 32'(sa), 32'(S_NONE));
        check("pd_eval3_done", 32'(done_a), 32'd0);
        edge_wait(); #1;
        check("pd_q_strobes", 32'(sa), 32'(S_NONE));
        check("pd_q_done", 32'(done_a), 32'd1);
        check("pd_q_wins", 32'({pw_a, dw_a}), 32'b01);

        // Player third card 4: dealer 5 draws.
        deal_to_eval_a();
        pscore = 4'd4; dscore = 4'd5;
        edge_wait(); #1; check("pd4_p3", 32'(sa), 32'(S_P3));
        pcard3 = 4'd4;
        edge_wait(); #1; check("pd4_eval3", 32'(sa), 32'(S_NONE));
        edge_wait(); #1;
        check("pd4_d3", 32'(sa), 32'(S_D3));
        check("pd4_d3_done", 32'(done_a), 32'd0);
        edge_wait(); #1;
        check("pd4_done_strobes", 32'(sa), 32'(S_NONE));
        check("pd4_done", 32'(done_a), 32'd1);

        // step low for three edges in D1.
        reset_a();
        edge_wait(); #1; check("hold_p1", 32'(sa), 32'(S_P1));
        edge_wait(); #1; check("hold_d1", 32'(sa), 32'(S_D1));
        step = 1'b0; #1;
        check("hold_gate", 32'(sa), 32'(S_NONE));
        for (int i = 0; i < 3; i++) begin
            edge_wait(); #1;
            check($sformatf("hold_%0d", i), 32'({sa, done_a}), 32'd0);
        end
        step = 1'b1; #1;
        check("hold_resume_d1", 32'(sa), 32'(S_D1));
        edge_wait(); #1; check("hold_next_p2", 32'(sa), 32'(S_P2));

        // Auto-restart instance; dut_a parked in reset.
        resetb_a = 1'b0;
        resetb_b = 1'b0;
        step = 1'b1; pscore = 4'd9; dscore = 4'd0; pcard3 = 4'd1;
        #1;
        check("b_rst_strobes", 32'(sb), 32'(S_NONE));
        check("b_rst_rounds", 32'(rounds_b), 32'd0);
        resetb_b = 1'b1;
        edge_wait(); #1; check("b_p1", 32'(sb), 32'(S_P1));
        repeat (4) edge_wait();
        edge_wait(); #1;
        check("b_r1_done", 32'(done_b), 32'd1);
        check("b_r1_pw", 32'(pw_b), 32'd1);
        check("b_r1_rounds", 32'(rounds_b), 32'd1);
        edge_wait(); #1;
        check("b_clear", 32'(sb), 32'(S_CLR));
        check("b_clear_done", 32'(done_b), 32'd0);
        edge_wait(); #1; check("b_restart_p1", 32'(sb), 32'(S_P1));
        repeat (5) edge_wait();
        #1;
        check("b_r2_done", 32'(done_b), 32'd1);
        check("b_r2_rounds", 32'(rounds_b), 32'd2);
        for (int i = 0; i < 253; i++) repeat (7) edge_wait();
        #1;
        check("b_r255_rounds", 32'(rounds_b), 32'd255);
        check("b_r255_done", 32'(done_b), 32'd1);
        repeat (7) edge_wait();
        #1;
        check("b_sat_rounds", 32'(rounds_b), 32'd255);
        check("b_sat_done", 32'(done_b), 32'd1);

        // Asynchronous reset in the middle of P3.
        pscore = 4'd4; dscore = 4'd5;
        repeat (7) edge_wait();
        #1;
        check("b_p3", 32'(sb), 32'(S_P3));
        #4;
        resetb_b = 1'b0;
        #1;
        check("b_async_strobes", 32'(sb), 32'(S_NONE));
        check("b_async_flags", 32'({done_b, pw_b, dw_b}), 32'd0);
        check("b_async_rounds", 32'(rounds_b), 32'd0);
        resetb_b = 1'b1;
        edge_wait(); #1;
        check("b_after_rst_p1", 32'(sb), 32'(S_P1));
        check("b_after_rst_rounds", 32'(rounds_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
